// File: rtl/mul_shift_add.sv
// Sequential shift-and-add multiplier: one multiplier bit per cycle on operand
// magnitudes, with the sign applied on the final edge and early exit on zero.
module mul_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic               sign;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   mplier_next;

  // Magnitudes stay WIDTH-bit unsigned so the most-negative value maps exactly.
  always_comb begin
    mag_a       = (signed_mode && a_in[WIDTH-1]) ? -a_in : a_in;
    mag_b       = (signed_mode && b_in[WIDTH-1]) ? -b_in : b_in;
    mplier_next = mplier >> 1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      sign   <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            sign   <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            state  <= (mag_b == '0) ? FINISH : RUN;
          end
        end
        RUN: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          if (mplier_next == '0) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          result <= sign ? -acc : acc;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_shift_add.sv
// Directed bench for mul_shift_add: an 8-bit instance for the hand-computed
// vectors and a 16-bit instance checked against a simple reference product.
module tb_mul_shift_add;

  logic        clk;
  logic        rst;

  logic        start8, mode8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] result8;

  logic        start16, mode16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [31:0] result16;

  int checks;
  int errors;

  mul_shift_add #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(mode8),
    .a_in(a8), .b_in(b8), .busy(busy8), .done(done8), .result(result8)
  );

  mul_shift_add #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(mode16),
    .a_in(a16), .b_in(b16), .busy(busy16), .done(done16), .result(result16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one 8-bit multiply and check result, latency, busy length, pulse width
  // and result stability while the multiply is in flight.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic mode,
                      input logic [15:0] exp_res, input int exp_lat,
                      input int exp_busy, input bit release_rst, input string name);
    int lat;
    int busy_cnt;
    logic [15:0] prev;
    bit unstable;
    @(negedge clk);
    if (release_rst) rst = 1'b0;
    start8 = 1'b1; a8 = a; b8 = b; mode8 = mode;
    prev = result8;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; busy_cnt = 0; unstable = 0;
    while (!done8 && lat < 100) begin
      if (busy8) busy_cnt++;
      if (result8 !== prev) unstable = 1;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!done8) begin
      errors++;
      $display("[TB] FAIL %s timeout: done never rose within %0d edges", name, lat);
    end
    checks++;
    if (result8 !== exp_res) begin
      errors++;
      $display("[TB] FAIL %s result: got %h expected %h", name, result8, exp_res);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (unstable) begin
      errors++;
      $display("[TB] FAIL %s result_stable: got changed expected held %h", name, prev);
    end
    if (exp_busy >= 0) begin
      checks++;
      if (busy_cnt !== exp_busy) begin
        errors++;
        $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_busy);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s done_pulse: got %b expected 0", name, done8);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 0; mode8 = 0; a8 = 0; b8 = 0;
    start16 = 0; mode16 = 0; a16 = 0; b16 = 0;
    #2;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || result8 !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset8: got busy=%b done=%b result=%h expected 0 0 0000", busy8, done8, result8);
    end
    checks++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || result16 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset16: got busy=%b done=%b result=%h expected 0 0 0", busy16, done16, result16);
    end
    repeat (2) @(posedge clk);
    // Release happens inside run8 so the very first post-reset edge samples start.
    run8(8'd6, 8'd7, 1'b0, 16'd42, 4, 4, 1'b1, "first_after_reset");
  endtask

  task automatic test_basic();
    run8(8'd20,  8'd23,  1'b0, 16'h01CC, 6, 6, 1'b0, "u20x23");
    run8(8'hFD,  8'd5,   1'b1, 16'hFFF1, 4, 4, 1'b0, "s_m3x5");
    run8(8'hFD,  8'd5,   1'b0, 16'h04F1, 4, 4, 1'b0, "u253x5");
    run8(8'd7,   8'hFE,  1'b1, 16'hFFF2, 3, 3, 1'b0, "s7x_m2");
    run8(8'hFF,  8'hFF,  1'b1, 16'h0001, 2, 2, 1'b0, "s_m1x_m1");
  endtask

  task automatic test_boundary();
    run8(8'h80, 8'h80, 1'b1, 16'd16384, 9, 9, 1'b0, "s_min_x_min");
    run8(8'hFF, 8'hFF, 1'b0, 16'd65025, 9, 9, 1'b0, "u255x255");
    run8(8'd77, 8'd0,  1'b0, 16'd0,     1, 1, 1'b0, "b_zero");
    run8(8'h80, 8'd1,  1'b1, 16'hFF80,  2, 2, 1'b0, "s_min_x1");
  endtask

  task automatic test_ignore_busy();
    int lat;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd5; b8 = 8'd200; mode8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 100) begin
      if (lat == 2 || lat == 5) begin
        start8 = 1'b1; a8 = 8'd1; b8 = 8'd1; mode8 = 1'b1;
      end else begin
        start8 = 1'b0; a8 = 8'd99; b8 = 8'd3;
      end
      @(posedge clk); #1;
      lat++;
    end
    start8 = 1'b0;
    checks++;
    if (result8 !== 16'd1000 || lat !== 9) begin
      errors++;
      $display("[TB] FAIL ignore_busy: got result=%0d lat=%0d expected 1000 lat=9", result8, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd2; b8 = 8'd2; mode8 = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (!done8 && lat < 100) begin
      a8 = 8'd3; b8 = 8'd3;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (result8 !== 16'd4 || lat !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_first: got result=%0d lat=%0d expected 4 lat=3", result8, lat);
    end
    // start is still high during the done cycle, so the next edge must accept it.
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_gap: got busy=%b expected 1", busy8);
    end
    lat = 0;
    while (!done8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (result8 !== 16'd9 || lat !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_second: got result=%0d lat=%0d expected 9 lat=3", result8, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd255; b8 = 8'd255; mode8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || result8 !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got busy=%b done=%b result=%h expected 0 0 0000", busy8, done8, result8);
    end
    saw_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("[TB] FAIL reset_no_done: got done pulse expected none");
    end
    run8(8'd9, 8'd11, 1'b0, 16'd99, 5, 5, 1'b1, "after_mid_reset");
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic mode, input int idx);
    logic signed [31:0] sp;
    logic [31:0] exp_res;
    logic [15:0] mb;
    int k;
    int lat;
    if (mode) begin
      sp = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
      exp_res = sp;
    end else begin
      exp_res = {16'h0, a} * {16'h0, b};
    end
    mb = (mode && b[15]) ? (16'h0 - b) : b;
    k = 0;
    for (int i = 0; i < 16; i++) if (mb[i]) k = i + 1;
    @(negedge clk);
    start16 = 1'b1; a16 = a; b16 = b; mode16 = mode;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = ~a; b16 = ~b;
    lat = 0;
    while (!done16 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (result16 !== exp_res || lat !== k + 1) begin
      errors++;
      $display("[TB] FAIL w16_%0d a=%h b=%h m=%b: got %h lat=%0d expected %h lat=%0d",
               idx, a, b, mode, result16, lat, exp_res, k + 1);
    end
  endtask

  task automatic test_width16();
    run16(16'hFFFF, 16'hFFFF, 1'b1, 0);
    run16(16'hFFFF, 16'hFFFF, 1'b0, 1);
    run16(16'h8000, 16'h8000, 1'b1, 2);
    run16(16'h8000, 16'hFFFF, 1'b1, 3);
    run16(16'h1234, 16'h0000, 1'b1, 4);
    run16(16'h0000, 16'h7FFF, 1'b0, 5);
    run16(16'h8000, 16'h8000, 1'b0, 6);
    for (int i = 0; i < 16; i++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 10 + i);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_boundary();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_width16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_shift_add.md
MUL_SHIFT_ADD -- requirements
Module: mul_shift_add

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL provide port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL provide port a_in  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL provide port b_in  input  WIDTH  multiplier; sampled with start.
REQ-008 SHALL provide port busy  output  1  high while a multiply is in progress (RUN or FINISH).
REQ-009 SHALL provide port done  output  1  one-cycle pulse; result is valid when high.
REQ-010 SHALL provide port result  output  2*WIDTH  registered product; held until the next completion.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and FINISH; busy is 1 in RUN and FINISH only.
REQ-012 In IDLE with start=1, SHALL latch mode and operand magnitudes (|a|, |b|), latch product sign = a_msb XOR b_msb when signed_mode=1 (else 0), and clear the 2*WIDTH accumulator.
REQ-013 On that edge, SHALL enter FINISH directly if |b|=0, else RUN.
REQ-014 Each RUN edge: if multiplier LSB=1 then acc += shifted multiplicand; multiplicand <<= 1; multiplier >>= 1 (logical).
REQ-015 SHALL leave RUN for FINISH on the edge where the shifted multiplier becomes 0 (early termination); RUN length k = bit-length of |b|, k <= WIDTH.
REQ-016 The FINISH edge SHALL load result with acc (negated if sign=1), assert done for exactly one cycle, and return to IDLE.
REQ-017 Latency SHALL be k+1 edges from the start-sampling edge to the edge that raises done; b=0 gives 1.
REQ-018 Magnitude path SHALL be WIDTH-bit unsigned, so signed -2^(WIDTH-1) operands are exact (e.g. -128 * -128 = 16384 for WIDTH=8).
REQ-019 The product SHALL always be exact in 2*WIDTH bits with no truncation or overflow in either mode.
REQ-020 start while busy=1 SHALL be ignored; operand and mode changes during busy SHALL have no effect.
REQ-021 During the done cycle state SHALL be IDLE, so a start in that cycle SHALL be accepted (back-to-back operation).
REQ-022 result SHALL change only on a FINISH edge or on reset; it SHALL be stable in IDLE and RUN.
REQ-023 start held high continuously SHALL launch a new multiply on each IDLE cycle with fresh samples.

Reset
REQ-024 rst=1 SHALL asynchronously force state=IDLE, busy=0, done=0, result=0, and clear the accumulator and operand registers.
REQ-025 rst asserted mid-operation SHALL abort the multiply with no done pulse; the first start after release SHALL behave as from power-up.
REQ-026 start sampled on the first edge after rst deasserts SHALL be accepted.

Verification
REQ-027 WIDTH=8, unsigned, a=20, b=23 -> busy for 6 cycles, done after 6 edges, result=460 (16'h01CC).
REQ-028 WIDTH=8, signed, a=8'hFD (-3), b=5 -> k=3, done after 4 edges, result=16'hFFF1 (-15).
REQ-029 WIDTH=8, signed, a=8'h80, b=8'h80 -> result=16384; unsigned a=255, b=255 -> result=65025, done after 9 edges.
REQ-030 b=0, a=77 -> done after 1 edge, result=0; start pulsed again during busy of a 5*200 multiply -> ignored, result=1000.
REQ-031 Back-to-back: start held high in the done cycle with a=3, b=3 -> second result=9 with no idle gap; rst pulse during RUN -> busy=0, result=0, no done pulse.
REQ-032 WIDTH=16, random signed and unsigned pairs (including all-ones, minimum-negative and zero operands) -> result matches the reference product and latency matches k+1 on every run.
